// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants plus derived totals and sync windows.
// Shared by the timing generator and by pixel-stage benches.
package vga_timing_pkg;

    localparam int unsigned PosW = 10;

    localparam int unsigned HDisplay = 640;
    localparam int unsigned HFront   = 16;
    localparam int unsigned HSync    = 96;
    localparam int unsigned HBack    = 48;
    localparam int unsigned VDisplay = 480;
    localparam int unsigned VFront   = 10;
    localparam int unsigned VSync    = 2;
    localparam int unsigned VBack    = 33;

    localparam int unsigned HTotal     = HDisplay + HFront + HSync + HBack;
    localparam int unsigned VTotal     = VDisplay + VFront + VSync + VBack;
    localparam int unsigned HSyncStart = HDisplay + HFront;
    localparam int unsigned HSyncEnd   = HSyncStart + HSync - 1;
    localparam int unsigned VSyncStart = VDisplay + VFront;
    localparam int unsigned VSyncEnd   = VSyncStart + VSync - 1;

    function automatic logic in_window(input logic [PosW-1:0] pos,
                                       input int unsigned first,
                                       input int unsigned last);
        return (pos >= PosW'(first)) && (pos <= PosW'(last));
    endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster axis: wrapping position counter, registered sync pulse and
// next-state active-region decode for the parent to register.
module timing_axis
    import vga_timing_pkg::*;
#(
    parameter int unsigned Display = 640,
    parameter int unsigned Front   = 16,
    parameter int unsigned Sync    = 96,
    parameter int unsigned Back    = 48,
    parameter bit          SyncPol = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            advance_i,
    output logic [PosW-1:0] pos_o,
    output logic            wrap_o,
    output logic            active_next_o,
    output logic            sync_o
);

    localparam int unsigned Total     = Display + Front + Sync + Back;
    localparam int unsigned SyncStart = Display + Front;
    localparam int unsigned SyncEnd   = SyncStart + Sync - 1;

    logic [PosW-1:0] pos_q, pos_d;
    logic            sync_q, sync_d;

    always_comb begin
        wrap_o = advance_i && (pos_q == PosW'(Total - 1));
        pos_d  = pos_q;
        if (wrap_o) begin
            pos_d = '0;
        end else if (advance_i) begin
            pos_d = pos_q + PosW'(1);
        end
        // Decode from next-state so registered outputs line up with pos_q.
        active_next_o = (pos_d < PosW'(Display));
        sync_d        = in_window(pos_d, SyncStart, SyncEnd) ? SyncPol : ~SyncPol;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q  <= '0;
            sync_q <= ~SyncPol;
        end else begin
            pos_q  <= pos_d;
            sync_q <= sync_d;
        end
    end

    assign pos_o  = pos_q;
    assign sync_o = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: horizontal and vertical axes plus registered
// display_on and single-cycle line/frame start strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISPLAY  = HDisplay,
    parameter int unsigned H_FRONT    = HFront,
    parameter int unsigned H_SYNC     = HSync,
    parameter int unsigned H_BACK     = HBack,
    parameter int unsigned V_DISPLAY  = VDisplay,
    parameter int unsigned V_FRONT    = VFront,
    parameter int unsigned V_SYNC     = VSync,
    parameter int unsigned V_BACK     = VBack,
    parameter bit          H_SYNC_POL = 1'b0,
    parameter bit          V_SYNC_POL = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PosW-1:0] hpos,
    output logic [PosW-1:0] vpos,
    output logic            hsync,
    output logic            vsync,
    output logic            display_on,
    output logic            line_start,
    output logic            frame_start
);

    logic h_wrap, h_active_next;
    logic v_wrap, v_active_next;

    logic display_on_q, display_on_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;

    timing_axis #(
        .Display (H_DISPLAY),
        .Front   (H_FRONT),
        .Sync    (H_SYNC),
        .Back    (H_BACK),
        .SyncPol (H_SYNC_POL)
    ) u_h_axis (
        .clk           (clk),
        .reset         (reset),
        .advance_i     (1'b1),
        .pos_o         (hpos),
        .wrap_o        (h_wrap),
        .active_next_o (h_active_next),
        .sync_o        (hsync)
    );

    // Vertical axis steps only when the line wraps, so vsync moves on whole lines.
    timing_axis #(
        .Display (V_DISPLAY),
        .Front   (V_FRONT),
        .Sync    (V_SYNC),
        .Back    (V_BACK),
        .SyncPol (V_SYNC_POL)
    ) u_v_axis (
        .clk           (clk),
        .reset         (reset),
        .advance_i     (h_wrap),
        .pos_o         (vpos),
        .wrap_o        (v_wrap),
        .active_next_o (v_active_next),
        .sync_o        (vsync)
    );

    always_comb begin
        display_on_d  = h_active_next && v_active_next;
        line_start_d  = h_wrap;
        frame_start_d = v_wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            display_on_q  <= 1'b1;
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
        end else begin
            display_on_q  <= display_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign display_on  = display_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
